// File: rtl/genius_pkg.sv
// Shared definitions for the Genius game: button count, colour codes and the
// button-conditioner state encoding.
package genius_pkg;

    localparam int NUM_BTN = 3;
    localparam int CODE_W  = 2;

    // Colour codes shared with the game FSM and the sequence generator.
    localparam logic [CODE_W-1:0] COLOR_GREEN = 2'd0;
    localparam logic [CODE_W-1:0] COLOR_RED   = 2'd1;
    localparam logic [CODE_W-1:0] COLOR_BLUE  = 2'd2;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    function automatic logic pat_is_single(input logic [NUM_BTN-1:0] pat);
        logic [NUM_BTN-1:0] low_cleared;
        low_cleared = pat & (pat - NUM_BTN'(1));
        return (pat != '0) && (low_cleared == '0);
    endfunction

    // Index of the lowest set bit; only meaningful for a one-hot pattern.
    function automatic logic [CODE_W-1:0] pat_to_code(input logic [NUM_BTN-1:0] pat);
        logic [CODE_W-1:0] code;
        code = COLOR_GREEN;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (pat[i]) begin
                code = CODE_W'(i);
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/genius_sync_2ff.sv
// Two-flop synchroniser for a bus of independent asynchronous bits; both stages
// load a caller-supplied level while reset is asserted.
module genius_sync_2ff #(
    parameter int                WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_p0 <= RESET_VALUE;
            sync_p1 <= RESET_VALUE;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/genius_btn_conditioner.sv
// Push-button front end: synchronise, debounce press and release, and emit one
// press (or multi-press) pulse per physical press.
module genius_btn_conditioner
    import genius_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn,
    input  logic               enable,
    output logic               press_valid,
    output logic [CODE_W-1:0]  press_code,
    output logic               multi_press,
    output logic [NUM_BTN-1:0] btn_level
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_norm;
    logic [NUM_BTN-1:0] sync;

    btn_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [NUM_BTN-1:0] pat, pat_nxt;
    logic               accept;

    logic               press_valid_nxt;
    logic               multi_press_nxt;
    logic [CODE_W-1:0]  press_code_nxt;
    logic [NUM_BTN-1:0] btn_level_nxt;

    assign btn_norm = BTN_ACTIVE_LOW ? ~btn : btn;

    // Released level is 0 after normalisation, so reset parks the synchroniser there.
    genius_sync_2ff #(
        .WIDTH       (NUM_BTN),
        .RESET_VALUE ('0)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn_norm),
        .q     (sync)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            pat   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pat   <= pat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pat_nxt   = pat;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (sync != '0) begin
                    state_nxt = PRESS_WAIT;
                    pat_nxt   = sync;
                    cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (sync == '0) begin
                    state_nxt = IDLE;
                    pat_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (sync != pat) begin
                    pat_nxt = sync;
                    cnt_nxt = CNT_ONE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    accept    = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            HELD: begin
                // A different non-zero pattern is ignored until a full release.
                if (sync == '0) begin
                    state_nxt = RELEASE_WAIT;
                    cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync != '0) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    pat_nxt   = '0;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE;
                pat_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        press_valid_nxt = accept && enable && pat_is_single(pat);
        multi_press_nxt = accept && !pat_is_single(pat);
        press_code_nxt  = press_valid_nxt ? pat_to_code(pat) : press_code;
        btn_level_nxt   = '0;
        if (state_nxt == HELD || state_nxt == RELEASE_WAIT) begin
            btn_level_nxt = pat_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            press_valid <= 1'b0;
            multi_press <= 1'b0;
            press_code  <= '0;
            btn_level   <= '0;
        end else begin
            press_valid <= press_valid_nxt;
            multi_press <= multi_press_nxt;
            press_code  <= press_code_nxt;
            btn_level   <= btn_level_nxt;
        end
    end

endmodule

// File: doc/genius_btn_conditioner.md
Name: genius_btn_conditioner

Overview:
Upstream front end for the Genius game FSM. It takes the three raw push buttons and produces one clean, single-cycle press event per physical press, with a 2-bit colour code matching the sequence generator's current_number encoding. It replaces the raw "some button pressed" and "which button" paths. Synchronisation, debounce, one-shot generation and multi-press rejection all live in this block.

Parameters:
DEBOUNCE_CYCLES, 1000000, number of consecutive stable synchronised samples needed to accept a press or a release (20 ms at 50 MHz); must be >= 2
BTN_ACTIVE_LOW, 1, 1 = a raw button reads 0 when pressed (board KEYs); 0 = it reads 1 when pressed

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-low reset
btn  input  3  raw asynchronous push buttons; button i maps to code i
enable  input  1  1 = accepted presses are reported; 0 = presses are tracked but swallowed (game not in input phase)
press_valid  output  1  one-cycle pulse: a single button press was accepted
press_code  output  2  code of the accepted button (0..2); valid while press_valid=1, holds its last value otherwise
multi_press  output  1  one-cycle pulse: an accepted pattern had more than one button pressed
btn_level  output  3  debounced pressed pattern (1 = pressed), active-high

Behaviour:
- Reset (reset=0 at a clock edge):
  - state=IDLE, counter=0, captured pattern=0.
  - Both sync stages are loaded with the released level.
  - press_valid=0, multi_press=0, press_code=0, btn_level=0.
- Input path:
  - raw btn is normalised to active-high using BTN_ACTIVE_LOW, then passed through a 2-FF synchroniser per bit, giving sync[2:0].
  - The FSM acts only on sync.
- Counter: width $clog2(DEBOUNCE_CYCLES+1); it never wraps because it is cleared at every transition.
- IDLE:
  - If sync != 0: go to PRESS_WAIT, pat <= sync, cnt <= 1.
- PRESS_WAIT:
  - If sync == 0: back to IDLE (bounce rejected).
  - Else if sync != pat: pat <= sync, cnt <= 1 (restart).
  - Else if cnt == DEBOUNCE_CYCLES-1: accept, go to HELD.
  - Else cnt++.
- Accept:
  - Single bit set in pat and enable=1: press_valid=1 for exactly one cycle; press_code = index of the set bit.
  - More than one bit set in pat: multi_press=1 for one cycle, regardless of enable; press_valid stays 0.
  - enable=0 with a single bit set: no pulse.
  - HELD is entered in every case.
- HELD:
  - If sync == 0: go to RELEASE_WAIT, cnt <= 1.
  - A change to a different non-zero pattern is ignored; a new press requires a full release first.
- RELEASE_WAIT:
  - If sync != 0: back to HELD (release bounce).
  - Else if cnt == DEBOUNCE_CYCLES-1: go to IDLE.
  - Else cnt++.
- btn_level = pat in HELD and RELEASE_WAIT, 0 otherwise; it is registered and updates on the same edge as the state.
- Latency: if the raw press is first sampled at edge N and stays stable, press_valid is registered at edge N+DEBOUNCE_CYCLES+1 and is high for one cycle. The release debounce adds DEBOUNCE_CYCLES+1 edges before IDLE.
- At most one press_valid per physical press; holding a button never repeats.
- enable is sampled only on the accept edge. Toggling enable while in HELD never produces a late pulse.
- Reset mid-press: after reset is released, a button still held is treated as a new press and goes through the full debounce.
- press_valid and multi_press are never high in the same cycle.

Decomposition:
- Package genius_pkg holds:
  - NUM_BTN=3 and CODE_W=2
  - FSM state encoding: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT (2-bit)
  - the shared colour-code constants also used by the game FSM and the sequence generator
- One sub-module, genius_sync_2ff: parameterised width, synchronous active-low reset to a supplied reset value. It is instantiated once for the 3-bit btn bus.

Test Plan:
(All with DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1, enable=1 unless stated.)
- Clean press: btn 3'b111 -> 3'b110 at edge 0, held 20 cycles -> press_valid=1 only after edge 5, press_code=0, btn_level=3'b001; no further pulse while held; btn_level returns to 0 five edges after release.
- Bounce rejection: btn[1] toggles low/high every 2 cycles for 12 cycles, then stays high -> no press_valid, state back to IDLE, btn_level=0. Then hold btn[1] low -> exactly one pulse, press_code=1.
- Multi-press: btn=3'b010 (buttons 0 and 2) held 10 cycles -> multi_press one-cycle pulse at edge 5, press_valid never 1, btn_level=3'b101.
- Enable masking: enable=0, press btn[2] for 10 cycles, raise enable while still held, then release -> no press_valid at any time. The next press with enable=1 gives press_code=2.
- Release bounce: press btn[0], get the pulse, release with one 1-cycle re-press glitch -> no second press_valid; IDLE is reached only after 4 stable released samples.
- Reset mid-press: reset=0 for 2 cycles while in PRESS_WAIT with btn[1] held -> all outputs 0 during reset. After reset=1 with btn[1] still held, press_valid with code 1 is registered at the 5th edge after the first post-reset sample.
